// File: rtl/rrf.sv
// rrf: retirement register file holding the committed arch->phys map
//   clk, rst      : clock, synchronous active-high reset
//   dequeue_valid : ROB commit strobe
//   rob_out       : commit payload {phys_reg[10:5], arch_reg[4:0]}
//   free_valid    : one-cycle pulse, free_preg is returned to the free list
//   free_preg     : physical register being freed
//   rrf_map       : committed map, entry i = phys reg holding arch reg i
//   commit_count  : retired instructions since reset (wraps)
//   commit_x0     : pulse, the previous cycle's commit targeted x0
module rrf #(
    parameter int NUM_ARCH = 32,
    parameter int NUM_PHYS = 64,
    localparam int AW = $clog2(NUM_ARCH),
    localparam int PW = $clog2(NUM_PHYS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         dequeue_valid,
    input  logic [PW+AW-1:0]             rob_out,
    output logic                         free_valid,
    output logic [PW-1:0]                free_preg,
    output logic [NUM_ARCH-1:0][PW-1:0]  rrf_map,
    output logic [63:0]                  commit_count,
    output logic                         commit_x0
);
    logic [AW-1:0] a;
    logic [PW-1:0] p;
    assign a = rob_out[AW-1:0];
    assign p = rob_out[PW+AW-1:AW];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ARCH; i++) rrf_map[i] <= PW'(i);
            free_valid   <= 1'b0;
            free_preg    <= '0;
            commit_count <= '0;
            commit_x0    <= 1'b0;
        end else begin
            free_valid <= dequeue_valid;
            commit_x0  <= dequeue_valid && a == '0;
            if (dequeue_valid) begin
                // x0 results are never visible, so the new phys goes straight back
                free_preg    <= a == '0 ? p : rrf_map[a];
                commit_count <= commit_count + 64'd1;
                if (a != '0) rrf_map[a] <= p;
            end
        end
    end
endmodule

// File: doc/rrf.md
Name: rrf

Overview:
- Retirement register file: the architectural-to-physical map as of the last committed instruction.
- Consumes the ROB commit stream, one commit per cycle: dequeue valid plus rob_out_t, i.e. {phys_reg[10:5], arch_reg[4:0]}.
- On each commit it installs the new mapping and returns the superseded physical register to the free list.
- Exposes the full committed map so the RAT can restore it on flush, and keeps a retired-instruction counter.

Parameters:
- NUM_ARCH, 32, number of architectural registers (index width 5)
- NUM_PHYS, 64, number of physical registers (index width 6)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- dequeue_valid  input  1  ROB commit strobe for this cycle
- rob_out  input  rob_out_t (11)  commit payload: phys_reg [10:5], arch_reg [4:0]
- free_valid  output  1  freed physical register valid (to free list enqueue)
- free_preg  output  6  physical register being freed
- rrf_map  output  32x6  committed map, entry i = phys reg holding arch reg i
- commit_count  output  64  retired instructions since reset
- commit_x0  output  1  pulse: last cycle's commit targeted x0

Behaviour:
Clock and reset:
- Single clock domain (clk); rst is synchronous and active-high, sampled on posedge clk.
- Reset state:
  - map[i] = i for i in 0..31 (identity; phys 32..63 are owned by the free list).
  - free_valid = 0, free_preg = 0, commit_count = 0, commit_x0 = 0.
- rst has priority over a same-cycle dequeue_valid; that commit is dropped, with no map change and no free.

Commit, when dequeue_valid = 1 at posedge (a = arch_reg, p = phys_reg):
- a != 0:
  - map[a] <= p.
  - free_preg <= old map[a], the value before this edge.
  - free_valid <= 1.
- a == 0:
  - map unchanged; map[0] stays 0 permanently.
  - free_preg <= p, because a result written to x0 is never architecturally visible, so p returns immediately.
  - free_valid <= 1, commit_x0 <= 1.
- commit_count <= commit_count + 1 for either case; wraps modulo 2^64.

Idle and output timing:
- No commit: free_valid <= 0, commit_x0 <= 0, and free_preg holds its value (don't-care).
- Latency: free_valid/free_preg are registered, asserted exactly one cycle after the commit edge, one-cycle pulse per commit.
- rrf_map is driven directly from state, so a commit at edge N is visible on rrf_map after edge N.

Back-to-back and hazard rules:
- Back-to-back commits to the same a: the second commit frees the phys installed by the first, with no stale read.
- No backpressure: the free list always accepts. The free list depth must be at least NUM_PHYS - NUM_ARCH (32).
- No same-cycle write-forwarding on rrf_map is required. The RAT samples rrf_map only after the flush edge, and the ROB is drained or squashed before flush.
- phys_reg equal to the current map[a] is illegal input. It is not checked in RTL, and the bench asserts it never occurs.

Test Plan:
1. Reset, then read rrf_map -> map[i] == i for all i; free_valid = 0; commit_count = 0.
2. One commit {p=40, a=5} -> next cycle free_valid = 1, free_preg = 5; map[5] = 40; commit_count = 1; the cycle after, free_valid = 0.
3. Back-to-back commits {p=41, a=7} then {p=42, a=7} -> free_preg = 7 then 41 on consecutive cycles; final map[7] = 42; commit_count = 2.
4. Commit {p=50, a=0} -> free_valid = 1, free_preg = 50, commit_x0 = 1; map[0] remains 0.
5. rst asserted in the same cycle as commit {p=33, a=3} -> map[3] = 3, free_valid = 0 next cycle, commit_count = 0.
6. 1000 random legal commits, with phys drawn from a model free list -> free_preg matches the model every cycle; rrf_map matches the model; commit_count = 1000; no phys appears twice in the map.
